// File: rtl/i_ref_sweep_ctrl_if.sv
// Control/status bundle between the sweep controller and its host.
// The master side drives sweep requests; the slave side is the controller.
interface i_ref_sweep_ctrl_if #(
  parameter int BUS_WIDTH = 10
);
  logic                 enable;
  logic                 start;
  logic                 osc_det;
  logic [BUS_WIDTH-1:0] i_ref;
  logic                 ready;
  logic                 went_unstable;
  logic                 done;
  logic                 busy;

  modport master (
    output enable, start, osc_det,
    input  i_ref, ready, went_unstable, done, busy
  );

  modport slave (
    input  enable, start, osc_det,
    output i_ref, ready, went_unstable, done, busy
  );
endinterface

// File: rtl/i_ref_sweep_ctrl.sv
// Reference-current sweep controller: steps i_ref upward, holds each value for a
// settle window, and stops on saturation or on a debounced oscillation flag.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | parked at I_START, waiting for start
// S_SETTLE   | holding i_ref while the settle counter runs
// S_REPORT   | one-cycle ready pulse for the settled i_ref
// S_SAT      | sweep ended at the top of the range
// S_UNSTABLE | sweep ended on detected oscillation, i_ref frozen
module i_ref_sweep_ctrl #(
  parameter int BUS_WIDTH     = 10,
  parameter int I_START       = 0,
  parameter int STEP          = 4,
  parameter int SETTLE_CYCLES = 64,
  parameter int FILT_LEN      = 3
) (
  input  logic                clk,
  input  logic                rst,
  i_ref_sweep_ctrl_if.slave   bus
);

  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int FW = $clog2(FILT_LEN + 1);

  localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0]        FILT_MAX    = FW'(FILT_LEN);
  localparam logic [BUS_WIDTH-1:0] START_V     = BUS_WIDTH'(I_START);
  localparam logic [BUS_WIDTH-1:0] STEP_V      = BUS_WIDTH'(STEP);
  // Largest value that can still take one more step without wrapping.
  localparam logic [BUS_WIDTH-1:0] LIMIT       = BUS_WIDTH'((2 ** BUS_WIDTH) - 1 - STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_REPORT,
    S_SAT,
    S_UNSTABLE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [BUS_WIDTH-1:0] i_ref_q;
  logic [BUS_WIDTH-1:0] i_ref_nx;
  logic [SW-1:0]        settle_cnt;
  logic [SW-1:0]        settle_nx;
  logic [FW-1:0]        filt_cnt;
  logic                 s1;
  logic                 s2;
  logic                 watching;
  logic                 unstable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.osc_det;
      s2 <= s1;
    end
  end

  assign watching = (state == S_SETTLE) || (state == S_REPORT);

  // Debounce: only an unbroken run of FILT_LEN synchronized highs counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt <= '0;
    end else if (!bus.enable || !s2 || !watching) begin
      filt_cnt <= '0;
    end else if (filt_cnt != FILT_MAX) begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign unstable = (filt_cnt == FILT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      i_ref_q    <= START_V;
      settle_cnt <= '0;
    end else begin
      state      <= state_nx;
      i_ref_q    <= i_ref_nx;
      settle_cnt <= settle_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    i_ref_nx  = i_ref_q;
    settle_nx = settle_cnt;
    if (!bus.enable) begin
      state_nx  = S_IDLE;
      i_ref_nx  = START_V;
      settle_nx = '0;
    end else begin
      case (state)
        S_IDLE: begin
          i_ref_nx  = START_V;
          settle_nx = '0;
          if (bus.start) begin
            state_nx = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (unstable) begin
            state_nx = S_UNSTABLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            state_nx  = S_REPORT;
            settle_nx = '0;
          end else begin
            settle_nx = settle_cnt + 1'b1;
          end
        end
        S_REPORT: begin
          if (unstable) begin
            state_nx = S_UNSTABLE;
          end else if (i_ref_q > LIMIT) begin
            state_nx = S_SAT;
          end else begin
            state_nx  = S_SETTLE;
            i_ref_nx  = i_ref_q + STEP_V;
            settle_nx = '0;
          end
        end
        S_SAT, S_UNSTABLE: begin
          if (bus.start) begin
            state_nx  = S_SETTLE;
            i_ref_nx  = START_V;
            settle_nx = '0;
          end
        end
        default: begin
          state_nx  = S_IDLE;
          i_ref_nx  = START_V;
          settle_nx = '0;
        end
      endcase
    end
  end

  assign bus.i_ref         = i_ref_q;
  assign bus.ready         = (state == S_REPORT);
  assign bus.went_unstable = (state == S_UNSTABLE);
  assign bus.done          = (state == S_SAT) || (state == S_UNSTABLE);
  assign bus.busy          = watching;

endmodule

// File: tb/tb_i_ref_sweep_ctrl.sv
// Scoreboard bench for i_ref_sweep_ctrl: the driver queues expected ready,
// went_unstable and done events; a negedge monitor pops and compares them.
module tb_i_ref_sweep_ctrl;
  localparam int BW      = 10;
  localparam int I_START = 0;
  localparam int STEP    = 4;
  localparam int S       = 8;
  localparam int FL      = 3;
  localparam int PER     = S + 1;

  typedef struct {
    int   cyc;
    int   iref;
    logic wu;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  ev_t  rdy_q[$];
  ev_t  wu_q[$];
  ev_t  done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  i_ref_sweep_ctrl_if #(.BUS_WIDTH(BW)) bus ();

  i_ref_sweep_ctrl #(
    .BUS_WIDTH    (BW),
    .I_START      (I_START),
    .STEP         (STEP),
    .SETTLE_CYCLES(S),
    .FILT_LEN     (FL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int flags();
    return int'({bus.ready, bus.went_unstable, bus.done, bus.busy});
  endfunction

  task automatic wait_to(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic pulse_start(output int k);
    bus.start = 1'b1;
    k = edge_n + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic push_rdy(input int k, input int a, input int b);
    ev_t e;
    for (int n = a; n <= b; n++) begin
      e.cyc  = k + S + n * PER;
      e.iref = I_START + STEP * n;
      e.wu   = 1'b0;
      rdy_q.push_back(e);
    end
  endtask

  task automatic push_ev(input int which, input int cyc, input int iref, input logic wu);
    ev_t e;
    e.cyc  = cyc;
    e.iref = iref;
    e.wu   = wu;
    if (which == 0) wu_q.push_back(e);
    else            done_q.push_back(e);
  endtask

  logic prev_wu   = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin : mon
    ev_t e;
    if (bus.ready) begin
      if (rdy_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: got ready with i_ref %0d at edge %0d, expected none", bus.i_ref, edge_n);
      end else begin
        e = rdy_q.pop_front();
        chk("ready_edge", edge_n, e.cyc);
        chk("ready_i_ref", int'(bus.i_ref), e.iref);
        chk("ready_with_unstable", int'(bus.went_unstable), 0);
        chk("ready_busy", int'(bus.busy), 1);
      end
    end
    if (bus.went_unstable && !prev_wu) begin
      if (wu_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_unstable: got rise at edge %0d, expected none", edge_n);
      end else begin
        e = wu_q.pop_front();
        chk("unstable_edge", edge_n, e.cyc);
        chk("unstable_i_ref", int'(bus.i_ref), e.iref);
      end
    end
    if (bus.done && !prev_done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got rise at edge %0d, expected none", edge_n);
      end else begin
        e = done_q.pop_front();
        chk("done_edge", edge_n, e.cyc);
        chk("done_i_ref", int'(bus.i_ref), e.iref);
        chk("done_went_unstable", int'(bus.went_unstable), int'(e.wu));
      end
    end
    prev_wu   <= bus.went_unstable;
    prev_done <= bus.done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : drv
    int k;
    int j;
    rst         = 1'b1;
    bus.enable  = 1'b1;
    bus.start   = 1'b0;
    bus.osc_det = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle hold after reset.
    repeat (20) begin
      @(negedge clk);
      chk("idle_i_ref", int'(bus.i_ref), I_START);
      chk("idle_flags", flags(), 0);
    end

    // Sweep with a short glitch at step 3, then abort at i_ref=200.
    pulse_start(k);
    push_rdy(k, 0, 49);
    wait_to(k + 3 * PER + 1);
    bus.osc_det = 1'b1;
    repeat (2) @(negedge clk);
    bus.osc_det = 1'b0;
    wait_to(k + 50 * PER + 2);
    chk("pre_drop_i_ref", int'(bus.i_ref), 200);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("drop_i_ref", int'(bus.i_ref), 0);
    chk("drop_flags", flags(), 0);
    chk("drop_pending_ready", rdy_q.size(), 0);
    bus.enable = 1'b1;
    @(negedge clk);

    // Full sweep to saturation.
    pulse_start(k);
    push_rdy(k, 0, 255);
    push_ev(1, k + S + 255 * PER + 1, 1020, 1'b0);
    wait_to(k + S + 255 * PER + 4);
    chk("sat_i_ref", int'(bus.i_ref), 1020);
    chk("sat_flags", flags(), 4'b0010);

    // Restart from SAT; oscillation from mid-settle of i_ref=40.
    pulse_start(k);
    chk("restart1_i_ref", int'(bus.i_ref), 0);
    chk("restart1_flags", flags(), 4'b0001);
    push_rdy(k, 0, 9);
    j = k + 10 * PER + 2;
    wait_to(j - 1);
    bus.osc_det = 1'b1;
    push_ev(0, j + FL + 2, 40, 1'b1);
    push_ev(1, j + FL + 2, 40, 1'b1);
    wait_to(j + 30);
    chk("unst_i_ref", int'(bus.i_ref), 40);
    chk("unst_flags", flags(), 4'b0110);
    bus.osc_det = 1'b0;
    repeat (5) @(negedge clk);

    // Restart from UNSTABLE; instability lands on the REPORT of i_ref=80.
    pulse_start(k);
    chk("restart2_i_ref", int'(bus.i_ref), 0);
    chk("restart2_flags", flags(), 4'b0001);
    push_rdy(k, 0, 20);
    j = k + 20 * PER + S - (FL + 1);
    wait_to(j - 1);
    bus.osc_det = 1'b1;
    push_ev(0, k + 20 * PER + S + 1, 80, 1'b1);
    push_ev(1, k + 20 * PER + S + 1, 80, 1'b1);
    wait_to(k + 20 * PER + 20);
    chk("rep_unst_i_ref", int'(bus.i_ref), 80);
    chk("rep_unst_flags", flags(), 4'b0110);
    bus.osc_det = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of a sweep.
    pulse_start(k);
    push_rdy(k, 0, 1);
    wait_to(k + 2 * PER + 3);
    chk("pre_rst_i_ref", int'(bus.i_ref), 8);
    #2 rst = 1'b1;
    #1;
    chk("rst_i_ref", int'(bus.i_ref), 0);
    chk("rst_flags", flags(), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_flags", flags(), 0);

    repeat (10) @(negedge clk);
    chk("left_ready", rdy_q.size(), 0);
    chk("left_unstable", wu_q.size(), 0);
    chk("left_done", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
